gf2_poly_divider: RTL and testbench

GF2_POLY_DIVIDER -- requirements
Module: gf2_poly_divider

---
 rtl/gf2_div_pkg.sv | 28 ++
 rtl/gf2_div_step.sv | 34 +++
 rtl/gf2_poly_divider.sv | 145 ++++++++++++++
 tb/tb_gf2_poly_divider.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/gf2_div_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gf2_div_pkg
// Purpose : Shared definitions for the GF(2) polynomial divider.
//           - default operand sizes (divisor N bits, dividend/quotient 2*N)
//           - controller state encoding
//           - counter widths for the normalisation shift count k and the
//             division step counter
// Revision: 1.0 - initial release
// ============================================================================
package gf2_div_pkg;

  localparam int N_DEFAULT = 409;
  localparam int W_DEFAULT = 2 * N_DEFAULT;

  // k counts normalisation shifts (0..N-1); the step counter spans W+k steps.
  localparam int K_WIDTH   = $clog2(N_DEFAULT);
  localparam int CNT_WIDTH = $clog2(W_DEFAULT + N_DEFAULT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/gf2_div_step.sv
`default_nettype none
// ============================================================================
// Module  : gf2_div_step
// Purpose : One step of bit-serial carry-less long division.
//           The partial remainder is extended by the incoming dividend bit;
//           if the extended value's top bit is set, the normalised divisor
//           (whose implicit top bit is 1) is subtracted (XOR).
// Ports   : r_in   [N-2:0] current partial remainder R'
//           bit_in         next dividend bit (MSB-first)
//           d_low  [N-2:0] normalised divisor D' without its leading 1
//           r_out  [N-2:0] next partial remainder
//           q_bit          quotient bit produced by this step
// Revision: 1.0 - initial release
// ============================================================================
module gf2_div_step #(
  parameter int N = 409
) (
  input  logic [N-2:0] r_in,
  input  logic         bit_in,
  input  logic [N-2:0] d_low,
  output logic [N-2:0] r_out,
  output logic         q_bit
);

  logic [N-1:0] t;

  always_comb begin
    t     = {r_in, bit_in};
    q_bit = t[N-1];
    r_out = q_bit ? (t[N-2:0] ^ d_low) : t[N-2:0];
  end

endmodule
`default_nettype wire

// File: rtl/gf2_poly_divider.sv
`default_nettype none
// ============================================================================
// Module  : gf2_poly_divider
// Purpose : Sequential GF(2) polynomial divider, Q = A div D, R = A mod D.
//           The divisor is first normalised (shifted left k times until its
//           top bit is set); the dividend followed by k zero bits is then
//           divided one bit per cycle. Dividing A*x^k by D*x^k yields the
//           same quotient and a remainder of R*x^k, undone by a final >> k.
// Ports   : clk, rst            clock, synchronous active-high reset
//           start               request, sampled only when idle
//           dividend [W-1:0]    polynomial A (bit i = coeff of x^i)
//           divisor  [N-1:0]    polynomial D
//           busy                high whenever not idle
//           done                one-cycle result-valid pulse
//           err                 divide-by-zero flag, valid with done
//           quotient [W-1:0]    Q
//           remainder[N-2:0]    R
// Revision: 1.0 - initial release
// ============================================================================
module gf2_poly_divider
  import gf2_div_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] quotient,
  output logic [N-2:0] remainder
);

  localparam int KW = $clog2(N);
  localparam int CW = $clog2(W + N);

  state_t          state;
  logic [W-1:0]    a_sh;     // dividend, shifted out MSB-first
  logic [N-1:0]    d_sh;     // normalised divisor D'
  logic [N-2:0]    r_sh;     // partial remainder R'
  logic [W-1:0]    q_sh;     // quotient shift register
  logic [KW-1:0]   k;
  logic [CW-1:0]   step;
  logic [CW-1:0]   last_step;
  logic [N-2:0]    r_nxt;
  logic            q_bit;

  // After W shifts a_sh is all zeros, so its MSB naturally supplies the
  // k trailing zero bits.
  gf2_div_step #(.N(N)) u_step (
    .r_in   (r_sh),
    .bit_in (a_sh[W-1]),
    .d_low  (d_sh[N-2:0]),
    .r_out  (r_nxt),
    .q_bit  (q_bit)
  );

  assign last_step = CW'(W - 1) + CW'(k);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      a_sh      <= '0;
      d_sh      <= '0;
      r_sh      <= '0;
      q_sh      <= '0;
      k         <= '0;
      step      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh      <= dividend;
            d_sh      <= divisor;
            k         <= '0;
            q_sh      <= '0;
            r_sh      <= '0;
            step      <= '0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b1;
            if (divisor == '0) begin
              err   <= 1'b1;
              state <= DONE;
            end else begin
              err   <= 1'b0;
              state <= NORM;
            end
          end
        end

        NORM: begin
          if (d_sh[N-1]) begin
            step  <= '0;
            state <= DIV;
          end else begin
            d_sh <= d_sh << 1;
            k    <= k + 1'b1;
          end
        end

        DIV: begin
          a_sh <= a_sh << 1;
          r_sh <= r_nxt;
          q_sh <= {q_sh[W-2:0], q_bit};
          step <= step + 1'b1;
          if (step == last_step) begin
            quotient  <= {q_sh[W-2:0], q_bit};
            remainder <= r_nxt >> k;
            done      <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          // Arriving from DIV, done is already high: leave next edge.
          // Arriving directly from IDLE (zero divisor), raise done first.
          if (done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            done <= 1'b1;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gf2_poly_divider.sv
`default_nettype none
// ============================================================================
// Module  : tb_gf2_poly_divider
// Purpose : Self-checking bench for gf2_poly_divider. Expected results come
//           from a textbook long-division model on whole vectors; results
//           are also checked against A == Q*D xor R by carry-less multiply.
// Revision: 1.0 - initial release
// ============================================================================
module tb_gf2_poly_divider;

  localparam int N  = 409;
  localparam int W  = 818;
  localparam int XW = W + N;
  localparam int RW = 32 * ((W + 31) / 32);

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic         err;
  logic [W-1:0] quotient;
  logic [N-2:0] remainder;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  gf2_poly_divider #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .quotient  (quotient),
    .remainder (remainder)
  );

  task automatic chk(input string tag, input logic [XW-1:0] obs, input logic [XW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int degree(input logic [N-1:0] d);
    for (int i = N - 1; i >= 0; i--)
      if (d[i]) return i;
    return -1;
  endfunction

  // Schoolbook long division: cancel the highest set term of the running
  // remainder with a shifted copy of the divisor.
  task automatic ref_div(input logic [W-1:0] a, input logic [N-1:0] d,
                         output logic [W-1:0] q, output logic [N-2:0] r);
    logic [W-1:0] rem;
    int dd;
    q   = '0;
    rem = a;
    dd  = degree(d);
    if (dd < 0) begin
      r = '0;
    end else begin
      for (int i = W - 1; i >= dd; i--) begin
        if (rem[i]) begin
          q[i-dd] = 1'b1;
          rem     = rem ^ (W'(d) << (i - dd));
        end
      end
      r = rem[N-2:0];
    end
  endtask

  function automatic logic [XW-1:0] clmul(input logic [W-1:0] q, input logic [N-1:0] d);
    logic [XW-1:0] p;
    p = '0;
    for (int j = 0; j < N; j++)
      if (d[j]) p = p ^ (XW'(q) << j);
    return p;
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [RW-1:0] v;
    for (int i = 0; i < RW; i += 32) v[i+:32] = $urandom;
    return v[W-1:0];
  endfunction

  function automatic logic [N-1:0] rand_div(input int dd);
    logic [RW-1:0] v;
    logic [N-1:0]  d;
    for (int i = 0; i < RW; i += 32) v[i+:32] = $urandom;
    d = v[N-1:0];
    for (int i = dd + 1; i < N; i++) d[i] = 1'b0;
    d[dd] = 1'b1;
    return d;
  endfunction

  // Called at #1 after a rising edge with the DUT idle. The next edge is T0.
  task automatic run_op(input logic [W-1:0] a, input logic [N-1:0] d,
                        input bit disturb, input string tag);
    logic [W-1:0] eq;
    logic [N-2:0] er;
    logic [W-1:0] q_hold;
    int lat, exp_lat, dd;
    ref_div(a, d, eq, er);
    dd      = degree(d);
    exp_lat = (dd < 0) ? 1 : W + 2 * (N - 1 - dd) + 1;
    dividend = a;
    divisor  = d;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, " busy"}, XW'(busy), XW'(1));
    lat = 0;
    for (int c = 1; c <= 2000; c++) begin
      if (disturb && c == 300) begin
        start    = 1'b1;
        dividend = ~a;
        divisor  = ~d;
      end
      if (disturb && c == 301) start = 1'b0;
      @(posedge clk); #1;
      if (done) begin
        lat = c;
        break;
      end
    end
    start = 1'b0;
    chk({tag, " latency"}, XW'(lat), XW'(exp_lat));
    chk({tag, " err"}, XW'(err), XW'(dd < 0));
    chk({tag, " quotient"}, XW'(quotient), XW'(eq));
    chk({tag, " remainder"}, XW'(remainder), XW'(er));
    if (dd >= 0) begin
      chk({tag, " q*d^r"}, clmul(quotient, d) ^ XW'(remainder), XW'(a));
      chk({tag, " deg r"}, XW'(remainder >> dd), XW'(0));
    end
    q_hold = quotient;
    @(posedge clk); #1;
    chk({tag, " done pulse"}, XW'(done), XW'(0));
    chk({tag, " idle"}, XW'(busy), XW'(0));
    chk({tag, " hold q"}, XW'(quotient), XW'(q_hold));
  endtask

  initial begin
    logic [N-1:0] d;
    logic [W-1:0] a;
    int dd;

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", XW'(busy), XW'(0));
    chk("reset done", XW'(done), XW'(0));
    chk("reset err", XW'(err), XW'(0));
    chk("reset quotient", XW'(quotient), XW'(0));
    chk("reset remainder", XW'(remainder), XW'(0));
    rst = 1'b0;

    // 1 / 1, maximum normalisation
    run_op(W'(1), N'(1), 1'b0, "one_by_one");
    chk("one_by_one q const", XW'(quotient), XW'(1));

    // (x^408+x^87+1)*x^5 xor 3, no normalisation
    d = '0; d[408] = 1'b1; d[87] = 1'b1; d[0] = 1'b1;
    a = (W'(d) << 5) ^ W'(3);
    run_op(a, d, 1'b0, "trinomial");
    chk("trinomial q const", XW'(quotient), XW'(32));
    chk("trinomial r const", XW'(remainder), XW'(3));

    // divide by zero
    run_op(rand_w(), '0, 1'b0, "div_zero");
    chk("div_zero err const", XW'(err), XW'(1));

    // zero dividend
    run_op('0, N'(11), 1'b0, "zero_dividend");

    // start and operand changes mid-DIV are ignored
    run_op(rand_w(), rand_div(N - 1), 1'b1, "disturbed");

    // reset in NORM aborts; a start right after reset is accepted
    dividend = rand_w(); divisor = N'(1); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort busy", XW'(busy), XW'(0));
    chk("abort done", XW'(done), XW'(0));
    rst = 1'b0;
    run_op(rand_w(), rand_div(N - 3), 1'b0, "after_reset");

    // random operands, mostly high-degree divisors to bound run time
    for (int i = 0; i < 30; i++) begin
      if (i % 4 == 0) dd = int'($urandom_range(N - 1, 0));
      else            dd = int'($urandom_range(N - 1, N - 40));
      a = rand_w();
      if (i % 3 == 0) a = a >> $urandom_range(W - 1, 0);
      run_op(a, rand_div(dd), 1'b0, "random");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
